dcache: RTL and testbench

DCACHE -- requirements
Module: dcache

---
 rtl/dcache_if.sv | 37 +++
 rtl/dcache.sv | 111 +++++++++++
 tb/tb_dcache.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/dcache_if.sv
// dcache_if: bundles the CPU-side request/response signals and the
// memory-side block transfer signals of the data cache.
//   slave  : cache view (takes CPU requests and memory responses)
//   master : environment view (CPU plus memory)
// Ports (all logic):
//   read, write, address[7:0], writedata[7:0] : CPU request
//   readdata[7:0], busywait                   : CPU response / stall
//   mem_read, mem_write                       : block fetch / write-back request
//   mem_address[7-OFFSET_BITS:0]              : block address {tag,index}
//   mem_writedata[31:0], mem_readdata[31:0]   : block data, byte 0 in [7:0]
//   mem_busywait                              : memory busy
interface dcache_if #(
  parameter int OFFSET_BITS = 2
);
  logic                   read;
  logic                   write;
  logic [7:0]             address;
  logic [7:0]             writedata;
  logic [7:0]             readdata;
  logic                   busywait;
  logic                   mem_read;
  logic                   mem_write;
  logic [7-OFFSET_BITS:0] mem_address;
  logic [31:0]            mem_writedata;
  logic [31:0]            mem_readdata;
  logic                   mem_busywait;

  modport slave (
    input  read, write, address, writedata, mem_readdata, mem_busywait,
    output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );

  modport master (
    output read, write, address, writedata, mem_readdata, mem_busywait,
    input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/dcache.sv
// dcache: direct-mapped, write-back, write-allocate data cache with one
// 32-bit block per line. Hits complete in the request cycle; misses stall
// the CPU through busywait while the FSM writes back a dirty victim, fetches
// the block and installs it. The CPU request is re-evaluated in IDLE, where
// it then hits.
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset (clears valid/dirty, forces IDLE)
//   bus   : dcache_if.slave, CPU and memory sides
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | serve hits; on miss choose write-back or fetch
// WRITE_BACK | write the dirty victim block to memory
// FETCH      | read the requested block from memory into fetch_buf
// UPDATE     | install fetch_buf as the line (valid=1, dirty=0)
module dcache #(
  parameter int INDEX_BITS  = 3,
  parameter int OFFSET_BITS = 2
) (
  input logic     clk,
  input logic     rst_n,
  dcache_if.slave bus
);
  localparam int TAG_BITS = 8 - INDEX_BITS - OFFSET_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, WRITE_BACK, FETCH, UPDATE} state_t;

  state_t state, state_nx;

  logic [LINES-1:0]    valid;
  logic [LINES-1:0]    dirty;
  logic [TAG_BITS-1:0] tag_arr  [LINES];
  logic [31:0]         data_arr [LINES];
  logic [31:0]         fetch_buf;

  logic [TAG_BITS-1:0]    tag;
  logic [INDEX_BITS-1:0]  index;
  logic [OFFSET_BITS-1:0] offset;
  logic [31:0]            line;
  logic                   req;
  logic                   hit;
  logic                   wr_hit;

  assign tag    = bus.address[7 -: TAG_BITS];
  assign index  = bus.address[OFFSET_BITS +: INDEX_BITS];
  assign offset = bus.address[OFFSET_BITS-1:0];
  assign line   = data_arr[index];
  assign req    = bus.read | bus.write;
  assign hit    = valid[index] && (tag_arr[index] == tag);
  // READ together with WRITE falls through to the write path here.
  assign wr_hit = (state == IDLE) && bus.write && hit;

  assign bus.readdata = line[{offset, 3'b000} +: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx          = state;
    bus.busywait      = 1'b1;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_address   = {tag, index};
    bus.mem_writedata = line;
    unique case (state)
      IDLE: begin
        bus.busywait = req && !hit;
        if (req && !hit)
          state_nx = (valid[index] && dirty[index]) ? WRITE_BACK : FETCH;
      end
      WRITE_BACK: begin
        bus.mem_write   = 1'b1;
        bus.mem_address = {tag_arr[index], index};
        if (!bus.mem_busywait) state_nx = FETCH;
      end
      FETCH: begin
        bus.mem_read = 1'b1;
        if (!bus.mem_busywait) state_nx = UPDATE;
      end
      UPDATE: state_nx = IDLE;
    endcase
  end

  // Line status: only these bits need reset; the arrays below are don't-care
  // while their valid bit is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      dirty <= '0;
    end else if (wr_hit) begin
      dirty[index] <= 1'b1;
    end else if (state == UPDATE) begin
      valid[index] <= 1'b1;
      dirty[index] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (state == FETCH && !bus.mem_busywait) fetch_buf <= bus.mem_readdata;
    if (wr_hit) begin
      data_arr[index][{offset, 3'b000} +: 8] <= bus.writedata;
    end else if (state == UPDATE) begin
      data_arr[index] <= fetch_buf;
      tag_arr[index]  <= tag;
    end
  end
endmodule

// File: tb/tb_dcache.sv
module tb_dcache;
  localparam int MEM_LAT = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcache_if #(.OFFSET_BITS(2)) bus ();

  dcache #(.INDEX_BITS(3), .OFFSET_BITS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory model: a request is served on its MEM_LAT-th cycle.
  logic [31:0] mem [64];
  int          cnt = 0;

  assign bus.mem_readdata = mem[bus.mem_address];
  assign bus.mem_busywait = (bus.mem_read || bus.mem_write) && (cnt < MEM_LAT - 1);

  always @(posedge clk) begin
    if (bus.mem_read || bus.mem_write) begin
      if (!bus.mem_busywait) begin
        cnt <= 0;
        if (bus.mem_write) mem[bus.mem_address] <= bus.mem_writedata;
      end else begin
        cnt <= cnt + 1;
      end
    end else begin
      cnt <= 0;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int         cyc;
  logic       seen_wb, seen_fetch, wb_first;
  logic [5:0] wb_addr, fetch_addr;
  logic [31:0] wb_data;
  int         overlap;

  task automatic sample_mem();
    if (bus.mem_read && bus.mem_write) overlap++;
    if (bus.mem_write && !seen_wb) begin
      seen_wb = 1'b1;
      wb_addr = bus.mem_address;
      wb_data = bus.mem_writedata;
    end
    if (bus.mem_read && !seen_fetch) begin
      seen_fetch = 1'b1;
      fetch_addr = bus.mem_address;
      wb_first   = seen_wb;
    end
  endtask

  // Counts rising edges until busywait drops (bounded).
  task automatic wait_ready();
    cyc = 0; seen_wb = 0; seen_fetch = 0; wb_first = 0; overlap = 0;
    wb_addr = '0; fetch_addr = '0; wb_data = '0;
    while (bus.busywait && cyc < 100) begin
      sample_mem();
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic cpu(input logic rd, input logic wr, input logic [7:0] addr, input logic [7:0] wd);
    bus.read = rd; bus.write = wr; bus.address = addr; bus.writedata = wd;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[6'h05] = 32'h4433_2211;
    mem[6'h0D] = 32'h9988_7766;
    mem[6'h0A] = 32'h0000_C3A7;
    mem[6'h02] = 32'h1234_5678;
    bus.read = 0; bus.write = 0; bus.address = 0; bus.writedata = 0;

    #22 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_busywait", bus.busywait, 0);
    chk("reset_mem_read", bus.mem_read, 0);
    chk("reset_mem_write", bus.mem_write, 0);
    chk("reset_valid", dut.valid, 0);

    // Cold read miss
    cpu(1, 0, 8'h14, 8'h00);
    chk("cold_busy_now", bus.busywait, 1);
    wait_ready();
    chk("cold_cycles", cyc, 7);
    chk("cold_readdata", bus.readdata, 8'h11);
    chk("cold_no_wb", seen_wb, 0);
    chk("cold_fetch_addr", fetch_addr, 6'h05);

    // Read hit, other byte of same line
    cpu(1, 0, 8'h17, 8'h00);
    chk("hit_busywait", bus.busywait, 0);
    chk("hit_readdata", bus.readdata, 8'h44);
    chk("hit_no_mem_read", bus.mem_read, 0);

    // Write hit then read back
    cpu(0, 1, 8'h15, 8'hAB);
    chk("whit_busywait", bus.busywait, 0);
    @(posedge clk); #1;
    cpu(1, 0, 8'h15, 8'h00);
    chk("whit_readback", bus.readdata, 8'hAB);
    chk("whit_rd_busy", bus.busywait, 0);
    chk("whit_dirty5", dut.dirty[5], 1);

    // Dirty eviction by write to 0x35
    @(posedge clk); #1;
    cpu(0, 1, 8'h35, 8'hCD);
    wait_ready();
    chk("evict_cycles", cyc, 12);
    chk("evict_wb_seen", seen_wb, 1);
    chk("evict_wb_first", wb_first, 1);
    chk("evict_wb_addr", wb_addr, 6'h05);
    chk("evict_wb_data", wb_data, 32'h4433_AB11);
    chk("evict_fetch_addr", fetch_addr, 6'h0D);
    chk("evict_no_overlap", overlap, 0);
    @(posedge clk); #1;
    chk("evict_mem_image", mem[6'h05], 32'h4433_AB11);
    cpu(1, 0, 8'h35, 8'h00);
    chk("evict_rd_byte1", bus.readdata, 8'hCD);
    cpu(1, 0, 8'h34, 8'h00);
    chk("evict_rd_byte0", bus.readdata, 8'h66);

    // Reset in the middle of FETCH
    @(posedge clk); #1;
    cpu(1, 0, 8'h28, 8'h00);
    chk("rstf_miss", bus.busywait, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstf_in_fetch", bus.mem_read, 1);
    rst_n = 1'b0;
    #1;
    chk("rstf_mem_read_drop", bus.mem_read, 0);
    chk("rstf_valid_clear", dut.valid, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1;
    chk("rstf_reissue_miss", bus.busywait, 1);
    wait_ready();
    chk("rstf_cycles", cyc, 7);
    chk("rstf_readdata", bus.readdata, 8'hA7);

    // Previously cached line must miss after reset; write-back image is in memory
    cpu(1, 0, 8'h14, 8'h00);
    chk("post_rst_miss", bus.busywait, 1);
    wait_ready();
    chk("post_rst_cycles", cyc, 7);
    chk("post_rst_no_wb", seen_wb, 0);
    chk("post_rst_byte0", bus.readdata, 8'h11);
    cpu(1, 0, 8'h15, 8'h00);
    chk("post_rst_byte1", bus.readdata, 8'hAB);

    // READ and WRITE together on a clean miss: acts as a write
    cpu(1, 1, 8'h08, 8'h5A);
    wait_ready();
    chk("rw_cycles", cyc, 7);
    chk("rw_fetch_addr", fetch_addr, 6'h02);
    @(posedge clk); #1;
    cpu(1, 0, 8'h08, 8'h00);
    chk("rw_readback", bus.readdata, 8'h5A);
    chk("rw_rd_busy", bus.busywait, 0);
    chk("rw_dirty2", dut.dirty[2], 1);
    cpu(1, 0, 8'h09, 8'h00);
    chk("rw_other_byte", bus.readdata, 8'h56);

    cpu(0, 0, 8'h00, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
